// File: rtl/cbus_mem_responder.sv
// cbus_mem_responder: responder end of the cbus protocol, backed by an
// internal array of 64-bit words. Serves single and multi-beat reads and
// byte-strobed writes with FIXED or INCR bursts after a fixed first-beat
// latency.
//
// Optional build macro CBUS_MEM_STALL_EN: when defined, a 16-bit LFSR inserts
// pseudo-random stall cycles between beats. When undefined, beats are
// back-to-back and no LFSR exists.

package cbus_pkg;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01
   } cbus_burst_e;

   // Beat count encoding: MLENn carries n beats.
   typedef enum logic [3:0] {
      MLEN1, MLEN2, MLEN3, MLEN4, MLEN5, MLEN6, MLEN7, MLEN8,
      MLEN9, MLEN10, MLEN11, MLEN12, MLEN13, MLEN14, MLEN15, MLEN16
   } cbus_len_e;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [63:0] addr;
      logic [2:0]  size;
      logic [7:0]  strobe;
      cbus_len_e   len;
      cbus_burst_e burst;
      logic [63:0] data;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [63:0] data;
   } cbus_resp_t;

endpackage

module cbus_mem_responder
   import cbus_pkg::*;
#(
   parameter int unsigned MEM_WORDS = 4096,
   parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
   parameter int unsigned LATENCY   = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  cbus_req_t  req,
   output cbus_resp_t resp
);

   localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam int unsigned LAT_W = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      BEAT,
      DONE
   } state_t;

   state_t            state;
   state_t            state_nxt;

   logic [63:0]       mem [MEM_WORDS];

   logic              is_write_q;
   logic              fixed_q;
   logic [3:0]        beat_cnt;
   logic [LAT_W-1:0]  lat_cnt;
   logic [IDX_W-1:0]  idx;

   logic [63:0]       offset;
   logic [IDX_W-1:0]  req_idx;
   logic              stall;
   logic              beat_fire;
   logic              unused_req;

   // Word index of the incoming request; bits above the array size are
   // dropped so out-of-range addresses simply wrap into the array.
   assign offset  = req.addr - BASE_ADDR;
   assign req_idx = offset[IDX_W+2:3];

   // Transfer size and sub-word address bits do not affect this responder:
   // it always returns the full word and leaves lane selection to the
   // initiator.
   assign unused_req = ^{req.size, offset[63:IDX_W+3], offset[2:0]};

`ifdef CBUS_MEM_STALL_EN
   logic [15:0] lfsr;

   // Free-running LFSR (x^16+x^14+x^13+x^11+1) that decides stall cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr <= 16'hACE1;
      end else begin
         lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      end
   end

   assign stall = (state == BEAT) && lfsr[0];
`else
   assign stall = 1'b0;
`endif

   // A beat completes only while the initiator still holds valid and the
   // cycle is not stalled; a dropped valid aborts without a ready or write.
   assign beat_fire = (state == BEAT) && req.valid && !stall;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; DONE ignores req so a held-valid initiator always
   // sees one dead cycle before its next request is captured.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (req.valid) begin
               state_nxt = (LATENCY == 0) ? BEAT : WAIT;
            end
         end
         WAIT: begin
            if (!req.valid) begin
               state_nxt = IDLE;
            end else if (lat_cnt == LAT_W'(1)) begin
               state_nxt = BEAT;
            end
         end
         BEAT: begin
            if (!req.valid) begin
               state_nxt = IDLE;
            end else if (!stall && (beat_cnt == 4'd0)) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Request capture, latency countdown, and per-beat counter/index update.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         is_write_q <= 1'b0;
         fixed_q    <= 1'b0;
         beat_cnt   <= 4'd0;
         lat_cnt    <= '0;
         idx        <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req.valid) begin
                  is_write_q <= req.is_write;
                  fixed_q    <= (req.burst == BURST_FIXED);
                  beat_cnt   <= req.len;
                  lat_cnt    <= LAT_W'(LATENCY);
                  idx        <= req_idx;
               end
            end
            WAIT: begin
               if (req.valid) begin
                  lat_cnt <= lat_cnt - LAT_W'(1);
               end
            end
            BEAT: begin
               if (beat_fire) begin
                  if (beat_cnt != 4'd0) begin
                     beat_cnt <= beat_cnt - 4'd1;
                  end
                  if (!fixed_q) begin
                     idx <= idx + IDX_W'(1);
                  end
               end
            end
            DONE: begin
               beat_cnt <= 4'd0;
            end
         endcase
      end
   end

   // Byte-strobed write into the array at the edge that ends a write beat;
   // memory contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (beat_fire && is_write_q) begin
         for (int i = 0; i < 8; i++) begin
            if (req.strobe[i]) begin
               mem[idx][8*i +: 8] <= req.data[8*i +: 8];
            end
         end
      end
   end

   // Response drive: everything is zero except during a completed beat.
   always_comb begin
      resp = '0;
      if (beat_fire) begin
         resp.ready = 1'b1;
         resp.last  = (beat_cnt == 4'd0);
         resp.data  = is_write_q ? 64'd0 : mem[idx];
      end
   end

endmodule

// File: tb/tb_cbus_mem_responder.sv
// tb_cbus_mem_responder: directed test of cbus_mem_responder. Expected beats
// are queued as each transaction is issued and a monitor pops them as the
// responder drives ready.

module tb_cbus_mem_responder;
   import cbus_pkg::*;

   localparam int unsigned MEM_WORDS = 64;
   localparam int unsigned LAT       = 2;
   localparam logic [63:0] BASE      = 64'h8000_0000;

   typedef struct {
      logic [63:0] data;
      logic        last;
   } beat_t;

   logic       clk = 1'b0;
   logic       reset;
   cbus_req_t  req;
   cbus_resp_t resp;

   beat_t sb[$];
   beat_t mon_beat;
   int    errors = 0;
   int    checks = 0;
   int    cyc    = 0;

   cbus_mem_responder #(
      .MEM_WORDS (MEM_WORDS),
      .BASE_ADDR (BASE),
      .LATENCY   (LAT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .resp  (resp)
   );

   // Free-running clock and cycle counter.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Safety net so the run can never hang.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Timing comparison: exact normally, a lower bound when stalls may occur.
   task automatic check_timing(input string tag, input int observed, input int expected);
`ifdef CBUS_MEM_STALL_EN
      check_output(tag, 64'(observed >= expected), 64'd1);
`else
      check_output(tag, 64'(observed), 64'(expected));
`endif
   endtask

   task automatic expect_beat(input logic [63:0] d, input logic l);
      sb.push_back('{data: d, last: l});
   endtask

   // Monitor: every ready beat must match the head of the scoreboard, and
   // non-beat cycles must present an all-zero response.
   always @(negedge clk) begin
      if (!reset) begin
         if (resp.ready) begin
            if (sb.size() == 0) begin
               check_output("unexpected_beat", 64'(resp.ready), 64'd0);
            end else begin
               mon_beat = sb.pop_front();
               check_output("beat_data", resp.data, mon_beat.data);
               check_output("beat_last", 64'(resp.last), 64'(mon_beat.last));
            end
         end else begin
            check_output("idle_data", resp.data, 64'd0);
            check_output("idle_last", 64'(resp.last), 64'd0);
         end
      end
   end

   // Drives one request and waits for its final (or abort_after-th) beat.
   // Returns beat count, latency from drive to first ready, and the span
   // between first and last ready cycle. Ends one cycle into DONE when
   // keep_valid is set, otherwise in the following IDLE cycle.
   task automatic apply_stimulus(input logic w, input logic [63:0] addr,
                                 input cbus_len_e len, input cbus_burst_e burst,
                                 input logic [7:0] strb, input logic [63:0] data,
                                 input bit keep_valid, input int abort_after,
                                 output int nbeats, output int lat, output int span);
      int start;
      int first_cyc;
      int last_cyc;
      bit done;
      req.valid    = 1'b1;
      req.is_write = w;
      req.addr     = addr;
      req.size     = 3'd3;
      req.strobe   = strb;
      req.len      = len;
      req.burst    = burst;
      req.data     = data;
      start     = cyc;
      nbeats    = 0;
      first_cyc = -1;
      last_cyc  = -1;
      done      = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (resp.ready) begin
            nbeats++;
            if (nbeats == 1) first_cyc = cyc;
            last_cyc = cyc;
            if (resp.last || nbeats == abort_after) done = 1'b1;
         end
      end
      check_output("txn_done", 64'(done), 64'd1);
      @(posedge clk);
      #1;
      if (!keep_valid || !done) begin
         req.valid = 1'b0;
         @(posedge clk);
         #1;
      end
      lat  = first_cyc - start;
      span = last_cyc - first_cyc;
   endtask

   task automatic write_word(input int w, input logic [63:0] d, input logic [7:0] strb);
      int nb;
      int lat;
      int span;
      expect_beat(64'd0, 1'b1);
      apply_stimulus(1'b1, BASE + 64'(w) * 64'd8, MLEN1, BURST_INCR, strb, d,
                     1'b0, 0, nb, lat, span);
   endtask

   int nb;
   int lat;
   int span;
   int ready_seen;

   // Directed sequence.
   initial begin
      req   = '0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_output("reset_ready", 64'(resp.ready), 64'd0);
      check_output("reset_last", 64'(resp.last), 64'd0);
      check_output("reset_data", resp.data, 64'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Single read with latency check.
      write_word(0, 64'h1122334455667788, 8'hFF);
      expect_beat(64'h1122334455667788, 1'b1);
      apply_stimulus(1'b0, BASE, MLEN1, BURST_INCR, 8'h00, 64'd0, 1'b0, 0, nb, lat, span);
      check_output("single_nbeats", 64'(nb), 64'd1);
      check_timing("single_latency", lat, 1 + LAT);

      // Strobed write over zero, then read back.
      write_word(1, 64'd0, 8'hFF);
      write_word(1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
      expect_beat(64'h0000_0000_FFFF_FFFF, 1'b1);
      apply_stimulus(1'b0, BASE + 64'h8, MLEN1, BURST_INCR, 8'h00, 64'd0, 1'b0, 0, nb, lat, span);
      check_output("strobe_nbeats", 64'(nb), 64'd1);

      // INCR burst of four.
      for (int w = 2; w <= 5; w++) write_word(w, 64'(w + 8), 8'hFF);
      for (int w = 2; w <= 5; w++) expect_beat(64'(w + 8), 1'(w == 5));
      apply_stimulus(1'b0, BASE + 64'h10, MLEN4, BURST_INCR, 8'h00, 64'd0, 1'b0, 0, nb, lat, span);
      check_output("incr_nbeats", 64'(nb), 64'd4);
      check_timing("incr_span", span, 3);

      // FIXED burst stays on one word.
      write_word(7, 64'h55, 8'hFF);
      for (int b = 0; b < 4; b++) expect_beat(64'h55, 1'(b == 3));
      apply_stimulus(1'b0, BASE + 64'h38, MLEN4, BURST_FIXED, 8'h00, 64'd0, 1'b0, 0, nb, lat, span);
      check_output("fixed_nbeats", 64'(nb), 64'd4);

      // INCR burst wraps from the top word to word 0.
      write_word(MEM_WORDS - 1, 64'hAAAA, 8'hFF);
      expect_beat(64'hAAAA, 1'b0);
      expect_beat(64'h1122334455667788, 1'b1);
      apply_stimulus(1'b0, BASE + 64'(MEM_WORDS - 1) * 64'd8, MLEN2, BURST_INCR, 8'h00, 64'd0,
                     1'b0, 0, nb, lat, span);
      check_output("wrap_nbeats", 64'(nb), 64'd2);

      // Walker style: valid held, address switched during the DONE cycle.
      expect_beat(64'd10, 1'b1);
      apply_stimulus(1'b0, BASE + 64'h10, MLEN1, BURST_INCR, 8'h00, 64'd0, 1'b1, 0, nb, lat, span);
      check_output("walker_a_nbeats", 64'(nb), 64'd1);
      expect_beat(64'd11, 1'b1);
      apply_stimulus(1'b0, BASE + 64'h18, MLEN1, BURST_INCR, 8'h00, 64'd0, 1'b0, 0, nb, lat, span);
      check_output("walker_b_nbeats", 64'(nb), 64'd1);
      check_timing("walker_b_latency", lat, 2 + LAT);

      // Abort an eight-beat write after two beats.
      expect_beat(64'd0, 1'b0);
      expect_beat(64'd0, 1'b0);
      apply_stimulus(1'b1, BASE, MLEN8, BURST_INCR, 8'hFF, 64'hDEAD_BEEF_0000_0001,
                     1'b0, 2, nb, lat, span);
      check_output("abort_nbeats", 64'(nb), 64'd2);
      expect_beat(64'hDEAD_BEEF_0000_0001, 1'b0);
      expect_beat(64'hDEAD_BEEF_0000_0001, 1'b0);
      expect_beat(64'd10, 1'b0);
      expect_beat(64'd11, 1'b1);
      apply_stimulus(1'b0, BASE, MLEN4, BURST_INCR, 8'h00, 64'd0, 1'b0, 0, nb, lat, span);
      check_output("abort_readback_nbeats", 64'(nb), 64'd4);

      // Reset while waiting for the first beat.
      req.valid    = 1'b1;
      req.is_write = 1'b0;
      req.addr     = BASE + 64'h38;
      req.len      = MLEN4;
      req.burst    = BURST_FIXED;
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check_output("rst_wait_ready", 64'(resp.ready), 64'd0);
      check_output("rst_wait_data", resp.data, 64'd0);
      req.valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      ready_seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (resp.ready) ready_seen++;
      end
      check_output("rst_wait_no_beat", 64'(ready_seen), 64'd0);

      // Reset in the middle of a beat must clear the response at once.
      for (int b = 0; b < 8; b++) expect_beat(64'h55, 1'(b == 7));
      req.valid = 1'b1;
      req.len   = MLEN8;
      ready_seen = 0;
      for (int i = 0; i < 50 && ready_seen == 0; i++) begin
         @(negedge clk);
         if (resp.ready) ready_seen++;
      end
      check_output("rst_beat_reached", 64'(ready_seen), 64'd1);
      #1;
      reset = 1'b1;
      #1;
      check_output("rst_beat_ready", 64'(resp.ready), 64'd0);
      check_output("rst_beat_data", resp.data, 64'd0);
      sb.delete();
      req.valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      // Memory survives reset; then a full eight-beat INCR read.
      write_word(6, 64'h66, 8'hFF);
      expect_beat(64'hDEAD_BEEF_0000_0001, 1'b0);
      expect_beat(64'hDEAD_BEEF_0000_0001, 1'b0);
      for (int w = 2; w <= 5; w++) expect_beat(64'(w + 8), 1'b0);
      expect_beat(64'h66, 1'b0);
      expect_beat(64'h55, 1'b1);
      apply_stimulus(1'b0, BASE, MLEN8, BURST_INCR, 8'h00, 64'd0, 1'b0, 0, nb, lat, span);
      check_output("mlen8_nbeats", 64'(nb), 64'd8);
      check_timing("mlen8_span", span, 7);

      repeat (3) @(posedge clk);
      check_output("scoreboard_empty", 64'(sb.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cbus_mem_responder.md
Name: cbus_mem_responder

Overview:
- Responder end of the cbus protocol: accepts one cbus_req_t and answers with a cbus_resp_t beat stream, backed by an internal 64-bit word array.
- Serves as memory for page-table walkers, caches and the top-level bench, in place of the AXI bridge.
- Supports single and multi-beat reads and strobed writes, with FIXED and INCR bursts and a programmable first-beat latency.

Parameters:
- MEM_WORDS, 4096: number of 64-bit words; must be a power of two.
- BASE_ADDR, 64'h8000_0000: byte address mapped to word 0.
- LATENCY, 2: idle cycles between request capture and the first beat; 0 is legal.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  cbus_req_t  initiator request.
  - Fields used: valid, is_write, addr, size, strobe, len, burst, data.
  - The initiator holds the request stable until the beat with ready and last.
- resp  out  cbus_resp_t  response.
  - Fields driven: ready, last, data.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - On reset: state=IDLE, resp.ready=0, resp.last=0, resp.data=0, counters=0.
  - Memory contents are not reset.
  - Reset mid-burst aborts immediately, with no further beats; writes already committed remain.
- States: IDLE, WAIT, BEAT, DONE.
- IDLE, when req.valid=1:
  - Capture is_write, burst, len and the word index idx=((addr-BASE_ADDR)>>3) mod MEM_WORDS.
  - Load beat counter = len (beats = len+1; MLEN1=0 ... MLEN16=15).
  - Load latency counter = LATENCY.
  - Go to WAIT, or to BEAT directly if LATENCY=0.
- WAIT: decrement the latency counter; go to BEAT when it reaches 1.
- BEAT:
  - Each beat cycle drives resp.ready=1.
  - Read: resp.data=mem[idx].
  - Write: mem[idx] byte lanes with req.strobe[i]=1 take req.data, committed at the clock edge ending the beat; resp.data=0.
  - resp.last=1 when beat counter=0, then go to DONE; otherwise decrement the counter.
  - burst=INCR: idx advances by 1 per beat, wrapping mod MEM_WORDS.
  - burst=FIXED: idx is held.
- DONE:
  - Exactly one cycle with resp=0, then IDLE.
  - req is ignored in DONE. This guarantees a one-cycle gap, so an initiator that keeps valid high and changes addr after detecting the falling edge of ready&last is served fresh.
  - A request still valid and unchanged in the following IDLE cycle is served again; this is protocol-correct.
- Abort: req.valid=0 in WAIT or BEAT forces IDLE on the next edge.
  - No ready is driven in that cycle.
  - No write occurs in that cycle.
- Latency: with valid seen at edge t, the first ready is in cycle t+1+LATENCY.
  - An N-beat burst occupies N consecutive ready cycles when no stalls occur.
- resp.data outside beat cycles is 0. resp.ready and resp.last are never X.
- req.size is ignored: the full 64-bit word is always returned, and lane selection belongs to the initiator.
- Addresses below BASE_ADDR wrap by the modulo rule; no error is reported.

Optional Feature:
- Macro: CBUS_MEM_STALL_EN.
- Defined:
  - A 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) steps every cycle.
  - In BEAT, when lfsr[0]=1 the cycle is a stall: ready=0, no write, and the counter and idx are held.
  - Beats stay in order; the last beat is still flagged by last.
- Undefined: there is no LFSR logic and beats are back-to-back.

Test Plan:
- Read single:
  - Stimulus: preload mem[0]=64'h1122334455667788; with LATENCY=2, read addr=0x80000000, MLEN1.
  - Required: ready=last=1 in cycle t+3 with data=64'h1122334455667788, one cycle idle, then back to IDLE.
- Strobed write then read:
  - Stimulus: write 0x80000008 with data=64'hFFFF_FFFF_FFFF_FFFF and strobe=8'h0F over old 0, then read the same address.
  - Required: the read returns 64'h0000_0000_FFFF_FFFF.
- INCR burst:
  - Stimulus: MLEN4 read at 0x80000010 with words 2..5 = 10,11,12,13.
  - Required: four consecutive ready beats carrying 10,11,12,13; last=1 only on the fourth.
- FIXED burst and wrap:
  - Stimulus A: MLEN4 FIXED read of word 7 (=0x55).
  - Required A: four beats of 0x55.
  - Stimulus B: INCR MLEN2 at word MEM_WORDS-1.
  - Required B: data comes from word MEM_WORDS-1, then word 0.
- Walker-style back-to-back:
  - Stimulus: valid held high; addr changes to a new PTE address the cycle after the ready&last falling edge.
  - Required: the second address is served after DONE; no beat is driven from the stale address.
- Abort and reset:
  - Stimulus A: drop valid after beat 2 of an MLEN8 write.
  - Required A: only words 0..1 are modified, and the block is in IDLE next cycle.
  - Stimulus B: assert reset mid-WAIT.
  - Required B: resp=0 asynchronously and no beat follows.
- With CBUS_MEM_STALL_EN: an MLEN8 read still yields 8 in-order beats with correct data, and total cycles ≥ 8.
